uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 111 +++++++++++
 tb/tb_uart_tx_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a UART transmitter one byte at a time.
// Writes are queued in a DEPTH-entry array. A small drain FSM pops one byte,
// pulses tx_send and waits for the transmitter's busy handshake before it
// pops again.
// Optional feature: define UART_TX_FIFO_OVF_EN to enable the sticky overflow
// flag. When it is undefined, overflow is tied low and ovf_clr is ignored.

module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [7:0]    tx_data,
  output logic          tx_send,
  input  logic          tx_busy,
  input  logic          ovf_clr,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  state_t        state;
  state_t        next_state;
  logic          wr_accept;
  logic          pop;

  // A write is dropped whenever the FIFO is full, even if a pop frees a slot
  // in the same cycle, so full alone decides acceptance.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign wr_accept = wr_en && !full;

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Drain FSM: pop only from IDLE, then wait for busy to rise and fall.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = SEND;
        end
      end
      SEND:      next_state = WAIT_ACK;
      WAIT_ACK:  if (tx_busy)  next_state = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Storage array has no reset; stale contents are never read because
  // count gates every pop.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy, and the registered transmitter interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      tx_data <= 8'h00;
      tx_send <= 1'b0;
    end else begin
      tx_send <= pop;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      case ({wr_accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Sticky overflow: a dropped write sets the flag and wins over a clear in
  // the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
    else if (ovf_clr)       overflow <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. A registered transmitter model answers
// tx_send with a busy window. A scoreboard queue holds the bytes that should
// come out, in order.

module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic       ovf_clr;
  logic       overflow;

  int         checks;
  int         errors;
  int         send_count;
  int         busy_cnt;
  int         busy_len;
  logic       hold_busy;
  logic       prev_send;
  logic [7:0] exp_q[$];
  logic       exp_ovf;

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy),
    .ovf_clr  (ovf_clr),
    .overflow (overflow)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered transmitter model.
  // Busy rises the cycle after tx_send is sampled and lasts busy_len cycles.
  // hold_busy pins busy high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (hold_busy) begin
      tx_busy  <= 1'b1;
      busy_cnt <= 0;
    end else if (tx_send) begin
      tx_busy  <= 1'b1;
      busy_cnt <= busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Output monitor.
  // Each tx_send pulse must carry the next scoreboard byte, last one cycle,
  // and never overlap tx_busy.
  always @(negedge clk) begin
    if (tx_send) begin
      send_count++;
      checkOutput("send_pulse_width", 32'(prev_send), 32'(1'b0));
      checkOutput("send_while_busy", 32'(tx_busy), 32'(1'b0));
      if (exp_q.size() == 0) checkOutput("unexpected_send", 32'(1'b1), 32'(1'b0));
      else                   checkOutput("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    prev_send = tx_send;
  end

  // Drive one write strobe, starting and ending on a falling edge.
  // The byte is queued on the scoreboard only if the write should be accepted.
  task automatic applyStimulus(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Wait until the scoreboard is drained and the link is quiet for a few
  // cycles.
  task automatic waitDrain(input int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 4; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_busy && !tx_send) quiet++;
      else quiet = 0;
    end
    checkOutput("drain_done", 32'(quiet >= 4), 32'(1'b1));
  endtask

  // Send a primer byte, then pin busy high so the FSM parks in WAIT_DONE.
  task automatic primeAndHold(input logic [7:0] d);
    applyStimulus(d, 1'b1);
    @(negedge clk);
    checkOutput("prime_send", 32'(tx_send), 32'(1'b1));
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int saved;
    checks     = 0;
    errors     = 0;
    send_count = 0;
    prev_send  = 1'b0;
    hold_busy  = 1'b0;
    busy_len   = 2;
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    ovf_clr    = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rst_empty", 32'(empty), 32'(1'b1));
    checkOutput("rst_full", 32'(full), 32'(1'b0));
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_tx_send", 32'(tx_send), 32'(1'b0));
    checkOutput("rst_tx_data", 32'(tx_data), 32'h00);
    checkOutput("rst_overflow", 32'(overflow), 32'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte: tx_send follows one edge after the write is sampled.
    busy_len = 3;
    applyStimulus(8'h55, 1'b1);
    checkOutput("single_count1", 32'(count), 32'd1);
    checkOutput("single_no_send_yet", 32'(tx_send), 32'(1'b0));
    @(negedge clk);
    checkOutput("single_send", 32'(tx_send), 32'(1'b1));
    checkOutput("single_count0", 32'(count), 32'd0);
    waitDrain(200);
    checkOutput("single_empty", 32'(empty), 32'(1'b1));

    // Back-to-back burst with a 10-cycle transmitter.
    busy_len = 10;
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1);
    waitDrain(300);

    // Fill to full while the FSM is parked, then drop the 17th write.
    busy_len = 2;
    primeAndHold(8'hAA);
    for (int i = 0; i < 16; i++) applyStimulus(8'h10 + 8'(i), 1'b1);
    checkOutput("full_after_16", 32'(full), 32'(1'b1));
    checkOutput("count_16", 32'(count), 32'd16);
    applyStimulus(8'hEE, 1'b0);
    checkOutput("count_after_drop", 32'(count), 32'd16);
    checkOutput("overflow_set", 32'(overflow), 32'(exp_ovf));
    ovf_clr = 1'b1;
    applyStimulus(8'hEF, 1'b0);
    ovf_clr = 1'b0;
    checkOutput("overflow_set_wins", 32'(overflow), 32'(exp_ovf));
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checkOutput("overflow_cleared", 32'(overflow), 32'(1'b0));
    hold_busy = 1'b0;
    waitDrain(600);
    checkOutput("full_drained_empty", 32'(empty), 32'(1'b1));

    // Wrap: 40 bytes in groups of 8, so the pointers wrap at least twice.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'(i), 1'b1);
      if (i % 8 == 7) waitDrain(300);
    end

    // Simultaneous accepted write and pop with count 3.
    primeAndHold(8'hC0);
    for (int i = 1; i <= 3; i++) applyStimulus(8'hC0 + 8'(i), 1'b1);
    checkOutput("count_3", 32'(count), 32'd3);
    hold_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    applyStimulus(8'hC4, 1'b1);
    checkOutput("simul_pop", 32'(tx_send), 32'(1'b1));
    checkOutput("simul_count", 32'(count), 32'd3);
    waitDrain(300);

    // Reset mid-transfer with 5 bytes queued and the FSM in WAIT_DONE.
    primeAndHold(8'hD0);
    for (int i = 1; i <= 5; i++) applyStimulus(8'hD0 + 8'(i), 1'b1);
    checkOutput("count_5", 32'(count), 32'd5);
    rst_n = 1'b0;
    hold_busy = 1'b0;
    #1;
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_empty", 32'(empty), 32'(1'b1));
    checkOutput("midrst_tx_send", 32'(tx_send), 32'(1'b0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    saved = send_count;
    repeat (20) @(negedge clk);
    checkOutput("no_send_after_rst", 32'(send_count), 32'(saved));
    applyStimulus(8'h99, 1'b1);
    waitDrain(200);
    checkOutput("post_rst_send", 32'(send_count), 32'(saved + 1));
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
